alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Command-side initiator for the 16-bit-operand / 3-bit-op / 32-bit-result ALU. Buffers operand/op commands in a small FIFO and drives them one at a time onto the ALU input port. After a fixed settle window it captures the ALU result and returns it on a valid/ready response channel. Division by zero is flagged in hardware, not left to software.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >=2
SETTLE_CYCLES, 1, cycles ALU inputs are held before the result is sampled; >=1 (0 illegal)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_a  in  16  operand A
cmd_b  in  16  operand B
cmd_op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 not A, 111 not B
alu_a  out  16  registered operand A to ALU
alu_b  out  16  registered operand B to ALU
alu_op  out  3  registered op to ALU
alu_out  in  32  ALU result
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_data  out  32  captured result
rsp_op  out  3  op that produced rsp_data
rsp_div0  out  1  op was 011 with B==0
rsp_mismatch  out  1  self-check failure (see Optional Feature)
busy  out  1  state!=IDLE or FIFO non-empty

Behaviour:
- Reset (sync, rst=1 at edge): FIFO flushed, state IDLE, settle counter 0. All outputs 0 except cmd_ready=1. Applies mid-operation; any pending response is discarded.
- Push: at any edge with cmd_valid && cmd_ready. Pop: at the IDLE->SETTLE edge. Push and pop on the same edge leave the count unchanged. No push when full, even with a simultaneous pop.
- FSM IDLE: if FIFO non-empty at an edge, pop the head and register alu_a/alu_b/alu_op, load the counter with SETTLE_CYCLES, and go to SETTLE.
- FSM SETTLE: decrement at each edge. At the edge where the counter==1, capture the response, set rsp_valid=1, and go to RESP.
- Capture rules: rsp_data=alu_out and rsp_op=alu_op. If alu_op==011 && alu_b==0: rsp_data=32'hFFFF_FFFF, rsp_div0=1; otherwise rsp_div0=0.
- FSM RESP: rsp_valid and rsp_data/rsp_op/rsp_div0/rsp_mismatch are held stable until the rsp_valid && rsp_ready edge. At that edge, clear rsp_valid and go to IDLE.
- alu_a/alu_b/alu_op change only at an issue edge and otherwise hold their last values.
- Latency with SETTLE_CYCLES=1: command accepted at edge k, issued at k+1, rsp_valid at k+2.
- Throughput: one command per SETTLE_CYCLES+2 cycles with rsp_ready held high.
- FIFO pointers wrap modulo DEPTH. Order is strictly FIFO; no reordering.

Optional Feature:
ALU_SELFCHECK_EN
- Defined: an internal golden model is evaluated on the issued operands; rsp_mismatch=1 if it differs from the captured alu_out. Ops 011 (div) are excluded and never flag.
- Golden model, 32-bit with operands zero-extended: add A+B; sub A-B (two's complement, wraps); mul A*B; and A&B; or A|B; not A {16'h0,~A}; not B {16'h0,~B}.
- Not defined: rsp_mismatch is tied 0 and no model logic is synthesized.

Test Plan:
- Single add A=0,B=1,op=000, rsp_ready=1 -> rsp_valid at k+2; rsp_data=1, rsp_op=000, rsp_div0=0.
- Div by zero A=10,B=0,op=011 -> rsp_data=32'hFFFF_FFFF, rsp_div0=1. Then A=160,B=2,op=011 -> rsp_data=alu_out (80), rsp_div0=0.
- Backpressure: push DEPTH+1 commands (sub 150-50, mul 160*2, and, or, not A) with rsp_ready=0 -> cmd_ready falls after the FIFO fills. Responses are held stable, then drain in order (100, 320, ...) once rsp_ready=1.
- Simultaneous push/pop at count 2 -> count stays 2; busy stays 1 until the last response handshake.
- Reset asserted during SETTLE -> next edge: rsp_valid=0, busy=0, alu_a/alu_b/alu_op=0, FIFO empty; the following command completes normally.
- With ALU_SELFCHECK_EN, a bench ALU model forcing add 3+4 to 8 -> rsp_mismatch=1. Without the macro, the same stimulus gives rsp_mismatch=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command FIFO and issue/settle/response sequencer for the 16-bit/3-bit-op/32-bit ALU.
// Optional macro ALU_SELFCHECK_EN adds a golden-model check that drives rsp_mismatch.
module alu_op_sequencer #(
   parameter int DEPTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic [2:0]  cmd_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [2:0]  rsp_op,
   output logic        rsp_div0,
   output logic        rsp_mismatch,
   output logic        busy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       OP_DIV   = 3'b011;

   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

   state_t           state_q, state_d;
   logic [34:0]      fifo_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   level_q, level_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [15:0]      alu_a_q, alu_b_q;
   logic [2:0]       alu_op_q, rsp_op_q;
   logic [31:0]      rsp_data_q;
   logic             rsp_div0_q;
   logic             fifo_empty, fifo_full, push, pop, capture;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LVL_FULL);
   assign push       = cmd_valid && !fifo_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         settle_q <= '0;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         level_q  <= level_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d  = SETTLE;
               settle_d = CNT_W'(SETTLE_CYCLES);
            end
         end
         SETTLE: begin
            settle_d = settle_q - CNT_ONE;
            if (settle_q == CNT_ONE) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop       = 1'b0;
      capture   = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE:    pop       = !fifo_empty;
         SETTLE:  capture   = (settle_q == CNT_ONE);
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
      busy      = (state_q != IDLE) || !fifo_empty;
      cmd_ready = !fifo_full;
   end

   // Simultaneous push and pop leave the level unchanged.
   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         rsp_data_q <= '0;
         rsp_op_q   <= '0;
         rsp_div0_q <= 1'b0;
      end else begin
         if (pop) {alu_op_q, alu_b_q, alu_a_q} <= fifo_q[rd_ptr_q];
         if (capture) begin
            rsp_op_q <= alu_op_q;
            if (alu_op_q == OP_DIV && alu_b_q == 16'h0) begin
               rsp_data_q <= 32'hFFFF_FFFF;
               rsp_div0_q <= 1'b1;
            end else begin
               rsp_data_q <= alu_out;
               rsp_div0_q <= 1'b0;
            end
         end
      end
   end

`ifdef ALU_SELFCHECK_EN
   logic mismatch_q;

   function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
      logic [31:0] ax, bx;
      ax = {16'h0, a};
      bx = {16'h0, b};
      case (op)
         3'b000:  golden = ax + bx;
         3'b001:  golden = ax - bx;
         3'b010:  golden = ax * bx;
         3'b100:  golden = ax & bx;
         3'b101:  golden = ax | bx;
         3'b110:  golden = {16'h0, ~a};
         3'b111:  golden = {16'h0, ~b};
         default: golden = 32'h0;
      endcase
   endfunction

   // Division is never compared against the model.
   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch_q <= 1'b0;
      end else if (capture) begin
         mismatch_q <= (alu_op_q != OP_DIV) && (golden(alu_a_q, alu_b_q, alu_op_q) != alu_out);
      end
   end

   assign rsp_mismatch = mismatch_q;
`else
   assign rsp_mismatch = 1'b0;
`endif

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign rsp_data = rsp_data_q;
   assign rsp_op   = rsp_op_q;
   assign rsp_div0 = rsp_div0_q;

endmodule
